// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin shared nibble-serial ALU.
// Imported by the interface, the arbiter top and the nibble adder.
package alu_arb_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int MAX_NIBBLE_IDX = 7;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } AluOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ArbState;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle of the shared ALU: per-requester request/operands in,
// grant and completion status out. The arbiter uses the slave modport.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import alu_arb_pkg::*;

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    AluOp [NUM_REQ-1:0]       op;
    logic [NUM_REQ-1:0][31:0] word1;
    logic [NUM_REQ-1:0][31:0] word2;
    logic [NUM_REQ-1:0][2:0]  nibbles;

    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [31:0]              result;
    logic                     carry_out;

    modport master (
        output req, op, word1, word2, nibbles,
        input  gnt, busy, done, done_id, result, carry_out
    );

    modport slave (
        input  req, op, word1, word2, nibbles,
        output gnt, busy, done, done_id, result, carry_out
    );

endinterface

// File: rtl/alu_share_arbiter_nibble_adder.sv
// Combinational 4-bit adder slice used once per RUN cycle by the arbiter.
module nibble_adder
    import alu_arb_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                carry_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carry_in};

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one nibble-serial ADD/SUB unit among NUM_REQ requesters.
// Optional `ALU_ARB_CARRY_EXT_EN: ADD keeps rippling a live carry into upper nibbles.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ArbState              state;
    ArbState              state_next;
    logic                 busy;
    logic                 done;

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      winner;
    logic                 win_valid;

    AluOp                 op_l;
    logic [31:0]          word2_l;
    logic [2:0]           last_idx;
    logic [2:0]           idx;
    logic                 carry;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      done_id;
    logic [31:0]          result;
    logic                 carry_out;

    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_raw;
    logic [NIBBLE_W-1:0]  b_eff;
    logic [NIBBLE_W-1:0]  sum_nib;
    logic                 sum_carry;
    logic                 run_end;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        win_valid = 1'b0;
        winner    = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                winner    = ID_W'(cand);
            end
        end
    end

    assign a_nib = result[{idx, 2'b00} +: NIBBLE_W];

`ifdef ALU_ARB_CARRY_EXT_EN
    logic extend;

    // Past the requested count only the carry ripples in, so the b nibble is zero.
    assign b_raw   = (idx > last_idx) ? '0 : word2_l[{idx, 2'b00} +: NIBBLE_W];
    assign extend  = (op_l == ADD) && sum_carry && (idx != 3'(MAX_NIBBLE_IDX));
    assign run_end = (idx >= last_idx) && !extend;
`else
    assign b_raw   = word2_l[{idx, 2'b00} +: NIBBLE_W];
    assign run_end = (idx >= last_idx);
`endif

    assign b_eff = (op_l == SUB) ? ~b_raw : b_raw;

    nibble_adder u_nibble_adder (
        .a         (a_nib),
        .b         (b_eff),
        .carry_in  (carry),
        .sum       (sum_nib),
        .carry_out (sum_carry)
    );

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (win_valid) state_next = RUN;
            end
            RUN: begin
                if (run_end) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ---- grant, pointer and visible result registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            rr_ptr    <= '0;
            done_id   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt     <= NUM_REQ'(1) << winner;
                        rr_ptr  <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                        done_id <= winner;
                        result  <= bus.word1[winner];
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: NIBBLE_W] <= sum_nib;
                    if (run_end) carry_out <= sum_carry;
                end
                DONE: gnt <= '0;
                default: ;
            endcase
        end
    end

    // ---- latched operands and nibble sequencer (reloaded at every grant) ----
    always_ff @(posedge clk) begin
        if (state == IDLE && win_valid) begin
            op_l     <= bus.op[winner];
            word2_l  <= bus.word2[winner];
            last_idx <= bus.nibbles[winner];
            idx      <= '0;
            carry    <= (bus.op[winner] == SUB);
        end else if (state == RUN) begin
            carry <= sum_carry;
            if (!run_end) idx <= idx + 3'd1;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.done_id   = done_id;
    assign bus.result    = result;
    assign bus.carry_out = carry_out;

endmodule
